// File: rtl/tusca_agendador.sv
// TUSCA measurement/config sequencer: periodic DHT11 reads with retry and fault
// tracking, and arbitration of user config requests against an ongoing measurement.
module tusca_agendador #(
  parameter int PERIODO        = 100000000,
  parameter int TIMEOUT        = 5000000,
  parameter int MAX_TENTATIVAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       definir_config,
  input  logic       pronto_medida,
  input  logic       erro_medida,
  input  logic       pronto_config,
  input  logic       erro_config,
  output logic       medir_dht11,
  output logic       receber_config,
  output logic       atualizar,
  output logic       falha_sensor,
  output logic [2:0] db_estado,
  output logic [1:0] db_tentativas
);

  localparam int PW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PER_FIM = PW'(PERIODO - 1);
  localparam logic [TW-1:0] TO_FIM  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    MAX_T   = 3'(MAX_TENTATIVAS);

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    ESPERA   = 3'd1,
    MEDE     = 3'd2,
    AGUARDA  = 3'd3,
    ATUALIZA = 3'd4,
    CONFIG   = 3'd5,
    FALHA    = 3'd6
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [PW-1:0] cnt_per_q, cnt_per_d;
  logic [TW-1:0] cnt_to_q, cnt_to_d;
  logic [1:0]    tent_q, tent_d;
  logic          pend_q, pend_d;
  logic          falha_q, falha_d;
  logic          cfg_q;
  logic          medir_q, atual_q, receber_q;
  logic          req, falhou;
  logic [2:0]    tent_inc;

  always_comb begin
    req       = definir_config & ~cfg_q;
    falhou    = erro_medida | ((cnt_to_q == TO_FIM) & ~pronto_medida);
    tent_inc  = {1'b0, tent_q} + 3'd1;
    estado_d  = estado_q;
    cnt_per_d = '0;
    cnt_to_d  = '0;
    tent_d    = tent_q;
    pend_d    = pend_q | req;
    falha_d   = falha_q;
    case (estado_q)
      INICIAL: estado_d = MEDE;
      ESPERA: begin
        if (req) begin
          estado_d = CONFIG;
          pend_d   = 1'b0;
        end else if (cnt_per_q == PER_FIM) begin
          estado_d = MEDE;
        end else begin
          cnt_per_d = cnt_per_q + 1'b1;
        end
      end
      MEDE: estado_d = AGUARDA;
      AGUARDA: begin
        // erro wins over a simultaneous pronto
        if (falhou) begin
          tent_d   = tent_inc[1:0];
          estado_d = (tent_inc < MAX_T) ? MEDE : FALHA;
        end else if (pronto_medida) begin
          estado_d = ATUALIZA;
        end else begin
          cnt_to_d = cnt_to_q + 1'b1;
        end
      end
      ATUALIZA, FALHA: begin
        tent_d  = 2'd0;
        falha_d = (estado_q == FALHA);
        if (pend_q | req) begin
          estado_d = CONFIG;
          pend_d   = 1'b0;
        end else begin
          estado_d = ESPERA;
        end
      end
      CONFIG: begin
        pend_d = pend_q;
        if (pronto_config | erro_config | (cnt_to_q == TO_FIM)) begin
          estado_d = ESPERA;
        end else begin
          cnt_to_d = cnt_to_q + 1'b1;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  // Outputs are decoded from the current state and registered, so they lag it by one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      cnt_per_q <= '0;
      cnt_to_q  <= '0;
      tent_q    <= 2'd0;
      pend_q    <= 1'b0;
      falha_q   <= 1'b0;
      cfg_q     <= 1'b0;
      medir_q   <= 1'b0;
      atual_q   <= 1'b0;
      receber_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_per_q <= cnt_per_d;
      cnt_to_q  <= cnt_to_d;
      tent_q    <= tent_d;
      pend_q    <= pend_d;
      falha_q   <= falha_d;
      cfg_q     <= definir_config;
      medir_q   <= (estado_q == MEDE);
      atual_q   <= (estado_q == ATUALIZA);
      receber_q <= (estado_q == CONFIG);
    end
  end

  assign medir_dht11    = medir_q;
  assign atualizar      = atual_q;
  assign receber_config = receber_q;
  assign falha_sensor   = falha_q;
  assign db_estado      = estado_q;
  assign db_tentativas  = tent_q;

endmodule

// File: tb/tb_tusca_agendador.sv
// Directed cycle-by-cycle vectors for tusca_agendador with PERIODO=10, TIMEOUT=6,
// MAX_TENTATIVAS=3, plus a hand sequence for reset asserted during CONFIG.
module tb_tusca_agendador;

  logic       clock;
  logic       reset;
  logic       definir_config, pronto_medida, erro_medida, pronto_config, erro_config;
  logic       medir_dht11, receber_config, atualizar, falha_sensor;
  logic [2:0] db_estado;
  logic [1:0] db_tentativas;

  int n_pass  = 0;
  int n_total = 0;

  tusca_agendador #(
    .PERIODO       (10),
    .TIMEOUT       (6),
    .MAX_TENTATIVAS(3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .definir_config(definir_config),
    .pronto_medida (pronto_medida),
    .erro_medida   (erro_medida),
    .pronto_config (pronto_config),
    .erro_config   (erro_config),
    .medir_dht11   (medir_dht11),
    .receber_config(receber_config),
    .atualizar     (atualizar),
    .falha_sensor  (falha_sensor),
    .db_estado     (db_estado),
    .db_tentativas (db_tentativas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // in = {definir_config, pronto_medida, erro_medida, pronto_config, erro_config}
  // o  = {medir_dht11, atualizar, receber_config, falha_sensor}
  typedef struct {
    logic [4:0] in;
    int         n;
    int         st;
    logic [3:0] o;
    int         tent;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [4:0] in, input int n, input int st,
                              input logic [3:0] o, input int tent);
    vec_t r;
    r.in = in; r.n = n; r.st = st; r.o = o; r.tent = tent;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_outs(input string tag, input int st, input logic [3:0] o, input int tent);
    chk({tag, " db_estado"},      int'(db_estado),      st);
    chk({tag, " medir_dht11"},    int'(medir_dht11),    int'(o[3]));
    chk({tag, " atualizar"},      int'(atualizar),      int'(o[2]));
    chk({tag, " receber_config"}, int'(receber_config), int'(o[1]));
    chk({tag, " falha_sensor"},   int'(falha_sensor),   int'(o[0]));
    chk({tag, " db_tentativas"},  int'(db_tentativas),  tent);
  endtask

  initial begin
    reset = 1'b0;
    {definir_config, pronto_medida, erro_medida, pronto_config, erro_config} = 5'b0;

    // Scenario 1: first measurement right after reset, then a 10-cycle period
    add(5'b00000, 1, 0, 4'b0000, 0);
    add(5'b00000, 1, 2, 4'b0000, 0);
    add(5'b00000, 1, 3, 4'b1000, 0);
    add(5'b00000, 1, 3, 4'b0000, 0);
    add(5'b01000, 1, 3, 4'b0000, 0);
    add(5'b00000, 1, 4, 4'b0000, 0);
    add(5'b00000, 1, 1, 4'b0100, 0);
    add(5'b00000, 9, 1, 4'b0000, 0);
    add(5'b00000, 1, 2, 4'b0000, 0);
    // Scenario 2: erro_medida on every attempt
    add(5'b00100, 1, 3, 4'b1000, 0);
    add(5'b00000, 1, 2, 4'b0000, 1);
    add(5'b00100, 1, 3, 4'b1000, 1);
    add(5'b00000, 1, 2, 4'b0000, 2);
    add(5'b00100, 1, 3, 4'b1000, 2);
    add(5'b00000, 1, 6, 4'b0000, 3);
    add(5'b00000, 10, 1, 4'b0001, 0);
    add(5'b00000, 1, 2, 4'b0001, 0);
    // Scenario 3: no response, each attempt times out after 6 AGUARDA cycles
    add(5'b00000, 1, 3, 4'b1001, 0);
    add(5'b00000, 5, 3, 4'b0001, 0);
    add(5'b00000, 1, 2, 4'b0001, 1);
    add(5'b00000, 1, 3, 4'b1001, 1);
    add(5'b00000, 5, 3, 4'b0001, 1);
    add(5'b00000, 1, 2, 4'b0001, 2);
    add(5'b00000, 1, 3, 4'b1001, 2);
    add(5'b00000, 5, 3, 4'b0001, 2);
    add(5'b00000, 1, 6, 4'b0001, 3);
    add(5'b00000, 10, 1, 4'b0001, 0);
    add(5'b00000, 1, 2, 4'b0001, 0);
    // Successful measurement clears the sticky fault
    add(5'b01000, 1, 3, 4'b1001, 0);
    add(5'b00000, 1, 4, 4'b0001, 0);
    add(5'b00000, 1, 1, 4'b0100, 0);
    // Scenario 4: config request in ESPERA, held high afterwards
    add(5'b00000, 1, 1, 4'b0000, 0);
    add(5'b10000, 1, 1, 4'b0000, 0);
    add(5'b10000, 1, 5, 4'b0000, 0);
    add(5'b10010, 1, 5, 4'b0010, 0);
    add(5'b10000, 1, 1, 4'b0010, 0);
    add(5'b10000, 9, 1, 4'b0000, 0);
    add(5'b10000, 1, 2, 4'b0000, 0);
    // Scenario 5: request during AGUARDA becomes pending, CONFIG then times out
    add(5'b00000, 1, 3, 4'b1000, 0);
    add(5'b10000, 1, 3, 4'b0000, 0);
    add(5'b01000, 1, 3, 4'b0000, 0);
    add(5'b00000, 1, 4, 4'b0000, 0);
    add(5'b00000, 1, 5, 4'b0100, 0);
    add(5'b00000, 5, 5, 4'b0010, 0);
    add(5'b00000, 1, 1, 4'b0010, 0);
    add(5'b00000, 9, 1, 4'b0000, 0);
    add(5'b00000, 1, 2, 4'b0000, 0);
    // Scenario 6: simultaneous pronto+erro is a failure; pending flag no longer set
    add(5'b01100, 1, 3, 4'b1000, 0);
    add(5'b00000, 1, 2, 4'b0000, 1);
    add(5'b01000, 1, 3, 4'b1000, 1);
    add(5'b00000, 1, 4, 4'b0000, 1);
    add(5'b00000, 1, 1, 4'b0100, 0);
    add(5'b10000, 1, 1, 4'b0000, 0);
    add(5'b10000, 1, 5, 4'b0000, 0);
    add(5'b10000, 1, 5, 4'b0010, 0);

    repeat (3) @(posedge clock);
    #1;
    chk_outs("reset", 0, 4'b0000, 0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        {definir_config, pronto_medida, erro_medida, pronto_config, erro_config} = tbl[i].in;
        chk_outs($sformatf("row%0d.%0d", i, k), tbl[i].st, tbl[i].o, tbl[i].tent);
        @(posedge clock);
        #1;
      end
    end

    // Reset asserted mid-CONFIG clears everything without waiting for a clock edge
    {definir_config, pronto_medida, erro_medida, pronto_config, erro_config} = 5'b10000;
    chk_outs("cfg_before_reset", 5, 4'b0010, 0);
    reset = 1'b0;
    #1;
    chk_outs("async_reset", 0, 4'b0000, 0);
    definir_config = 1'b0;
    @(posedge clock);
    #1;
    chk_outs("reset_held", 0, 4'b0000, 0);
    reset = 1'b1;
    chk_outs("rerun_c0", 0, 4'b0000, 0);
    @(posedge clock);
    #1;
    chk_outs("rerun_c1", 2, 4'b0000, 0);
    @(posedge clock);
    #1;
    chk_outs("rerun_c2", 3, 4'b1000, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
